// File: rtl/aes_inv_cipher_if.sv
// Handshake/data bundle for the iterative AES-128 inverse cipher.
//   in_valid/in_ready  : ciphertext handshake, ct is the 16-byte state
//   rk_idx/rk          : indexed round-key read; rk answers rk_idx in the same cycle
//   out_valid/out_ready: plaintext handshake, pt is the 16-byte state
// State layout [3:0][3:0][7:0]: s[3-r][3-c] holds AES byte s(r,c).
// slave = cipher side, master = key store / producer / consumer side.
interface aes_inv_cipher_if;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][3:0][7:0]  ct;
  logic [3:0]            rk_idx;
  logic [3:0][3:0][7:0]  rk;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0][3:0][7:0]  pt;

  modport slave (
    input  in_valid, ct, rk, out_ready,
    output in_ready, rk_idx, out_valid, pt
  );

  modport master (
    output in_valid, ct, rk, out_ready,
    input  in_ready, rk_idx, out_valid, pt
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any block in flight
//   bus   : aes_inv_cipher_if.slave (ct in, pt out, round-key read port)
// Flow: IDLE accepts ct and adds round key 10; RUN performs rounds 9..0 with
// rk_idx = rnd; DONE holds pt until out_ready. 12 cycles per block.
module aes_inv_cipher #(
  parameter int NR = 10  // AES-128 only
) (
  input  logic            clk,
  input  logic            reset,
  aes_inv_cipher_if.slave bus
);

  typedef logic [3:0][3:0][7:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // GF(2^8) arithmetic, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine map (rotl 1, 3, 6, xor 0x05) followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = s[r][2'((c + 3 - r) % 4)];
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = inv_sbox(s[r][c]);
    return o;
  endfunction

  // Row index 3 is AES row 0, so an AES column top-to-bottom is s[3..0][c].
  function automatic state_t inv_mix_columns(input state_t s);
    state_t     o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[3][c];
      a1 = s[2][c];
      a2 = s[1][c];
      a3 = s[0][c];
      o[3][c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[2][c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[1][c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[0][c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  fsm_e       state_q, state_d;
  logic [3:0] rnd_q,   rnd_d;
  state_t     blk_q,   blk_d;
  state_t     pt_q,    pt_d;
  state_t     round_core;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d    = state_q;
    rnd_d      = rnd_q;
    blk_d      = blk_q;
    pt_d       = pt_q;
    round_core = inv_sub_bytes(inv_shift_rows(blk_q)) ^ bus.rk;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          blk_d   = bus.ct ^ bus.rk;
          rnd_d   = 4'(NR - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd_q == 4'd0) begin
          // Final round skips InvMixColumns and lands directly in pt.
          pt_d    = round_core;
          state_d = DONE;
        end else begin
          blk_d = inv_mix_columns(round_core);
          rnd_d = rnd_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      pt_q    <= pt_d;
    end
  end

  // NOTE: the working state register has no reset; IDLE always overwrites it
  // before RUN reads it, so an aborted block leaves nothing observable.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  // rk_idx depends on registered state only, never on inputs.
  assign bus.rk_idx    = (state_q == RUN) ? rnd_q : 4'(NR);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.pt        = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher: FIPS-197 vectors, rk_idx trace,
// backpressure, mid-block reset and back-to-back blocks against an
// encrypt-side reference model with its own key expansion and key store.
module tb_aes_inv_cipher;

  typedef logic [3:0][3:0][7:0] state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_if bus ();

  aes_inv_cipher #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  logic [127:0] rk_blk [11];
  state_t       rk_mem [11];

  // Key store: combinational answer to rk_idx.
  always_comb begin
    bus.rk = '0;
    if (bus.rk_idx <= 4'd10) bus.rk = rk_mem[bus.rk_idx];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Stream byte r+4c (byte 0 = MSB) lives at s[3-r][3-c].
  function automatic state_t to_state(input logic [127:0] b);
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[3-r][3-c] = b[127 - 8*(r + 4*c) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[127 - 8*(r + 4*c) -: 8] = s[3-r][3-c];
    return b;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk_blk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk_mem[r] = to_state(rk_blk[r]);
    end
  endtask

  // Forward cipher on stream bytes, used to produce ciphertexts for random plaintexts.
  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) b[i] = p[127 - 8*i -: 8] ^ rk_blk[0][127 - 8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4*c] = SBOX[b[r + 4*((c + r) % 4)]];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) b[i] = t[i] ^ rk_blk[rnd][127 - 8*i -: 8];
    end
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7],
            b[8], b[9], b[10], b[11], b[12], b[13], b[14], b[15]};
  endfunction

  // One full block. If out_ready is low on entry, pt is held for 20 cycles
  // while a second in_valid is offered, then out_ready is released.
  task automatic run_block(input string tag, input logic [127:0] ct_blk,
                           input logic [127:0] exp_pt, output int acc_cyc);
    int n;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_in_ready_idle"}, 128'(bus.in_ready), 128'd1);
    bus.ct       = to_state(ct_blk);
    bus.in_valid = 1'b1;
    check({tag, "_rk_idx_accept"}, 128'(bus.rk_idx), 128'd10);
    tick();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.ct       = ~to_state(ct_blk);
    n = 1;
    while (!bus.out_valid && n < 30) begin
      check({tag, "_rk_idx_run"}, 128'(bus.rk_idx), 128'(10 - n));
      check({tag, "_in_ready_run"}, 128'(bus.in_ready), 128'd0);
      tick();
      n++;
    end
    check({tag, "_latency_edges_incl_accept"}, 128'(n), 128'd11);
    check({tag, "_pt"}, from_state(bus.pt), exp_pt);
    if (!bus.out_ready) begin
      for (int k = 0; k < 20; k++) begin
        bus.in_valid = 1'b1;
        bus.ct       = to_state({$urandom, $urandom, $urandom, $urandom});
        tick();
        check({tag, "_hold_out_valid"}, 128'(bus.out_valid), 128'd1);
        check({tag, "_hold_in_ready"}, 128'(bus.in_ready), 128'd0);
        check({tag, "_hold_pt"}, from_state(bus.pt), exp_pt);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    tick();
    check({tag, "_out_valid_after_hs"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_in_ready_after_hs"}, 128'(bus.in_ready), 128'd1);
    check({tag, "_rk_idx_after_hs"}, 128'(bus.rk_idx), 128'd10);
  endtask

  initial begin
    int           acc0, acc1, acc2, guard;
    logic [127:0] p [3];

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ct        = '0;
    set_key(C1_KEY);
    tick();
    tick();
    check("reset_in_ready", 128'(bus.in_ready), 128'd1);
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_pt", from_state(bus.pt), 128'd0);
    check("reset_rk_idx", 128'(bus.rk_idx), 128'd10);
    reset = 1'b0;
    tick();

    // FIPS-197 C.1 with rk_idx trace and latency.
    run_block("c1", C1_CT, C1_PT, acc0);

    // FIPS-197 Appendix B under 20 cycles of backpressure.
    set_key(B_KEY);
    bus.out_ready = 1'b0;
    run_block("appb_bp", B_CT, B_PT, acc0);

    // Abort at rnd=5, then a fresh C.1 block.
    set_key(C1_KEY);
    bus.ct       = to_state(C1_CT);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.rk_idx != 4'd5 && guard < 20) begin
      tick();
      guard++;
    end
    check("abort_at_rnd5", 128'(bus.rk_idx), 128'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", 128'(bus.in_ready), 128'd1);
    check("abort_out_valid", 128'(bus.out_valid), 128'd0);
    check("abort_rk_idx", 128'(bus.rk_idx), 128'd10);
    check("abort_pt_cleared", from_state(bus.pt), 128'd0);
    run_block("c1_after_abort", C1_CT, C1_PT, acc0);

    // Back-to-back random blocks against the encrypt-side model.
    set_key({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 3; i++) p[i] = {$urandom, $urandom, $urandom, $urandom};
    run_block("b2b0", encrypt(p[0]), p[0], acc0);
    run_block("b2b1", encrypt(p[1]), p[1], acc1);
    run_block("b2b2", encrypt(p[2]), p[2], acc2);
    check("b2b_spacing_01", 128'(acc1 - acc0), 128'd12);
    check("b2b_spacing_12", 128'(acc2 - acc1), 128'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
